// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder for the pixel-clock domain.
// Inputs pass through colour expansion (or the colour-bar generator), a registered
// minimisation stage and a registered DC-balancing stage, for a fixed 2-cycle latency.
// Channel order inside packed arrays: [0] = blue, [1] = green, [2] = red.
module dvi_tmds_encoder #(
    parameter int unsigned RW       = 5,
    parameter int unsigned GW       = 6,
    parameter int unsigned BW       = 5,
    parameter bit          SYNC_INV = 1'b0,
    parameter int unsigned BAR_W    = 80
) (
    input  logic          clk_pixel,
    input  logic          reset_n,
    input  logic [RW-1:0] red,
    input  logic [GW-1:0] green,
    input  logic [BW-1:0] blue,
    input  logic          color_en,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          pattern_en,
    output logic [9:0]    tmds_b,
    output logic [9:0]    tmds_g,
    output logic [9:0]    tmds_r
);

    localparam logic [9:0]  CtrlBlank = 10'h354;
    localparam logic [11:0] BarLast   = 12'(BAR_W - 1);

    // Reject unsupported parameter values at elaboration.
    generate
        if (RW < 1 || RW > 8 || GW < 1 || GW > 8 || BW < 1 || BW > 8 ||
            BAR_W < 1 || BAR_W > 4095) begin : g_bad_param
            $error("dvi_tmds_encoder: parameter out of range");
        end
    endgenerate

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimised 9-bit word; bit 8 set means XOR chaining was used.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------------------------
    // Colour expansion: repeat the component MSB-first, keep the top 8 bits.
    logic [7:0] red_x, green_x, blue_x;

    for (genvar i = 0; i < 8; i++) begin : g_expand
        assign red_x[7-i]   = red[RW-1-(i%RW)];
        assign green_x[7-i] = green[GW-1-(i%GW)];
        assign blue_x[7-i]  = blue[BW-1-(i%BW)];
    end

    // ---------------------------------------------------------------------------------
    // Colour-bar generator. bar_pos/bar_idx track count / BAR_W incrementally; they
    // restart together with the 12-bit pixel counter when it wraps.
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [11:0] bar_pos_q, bar_pos_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [7:0]  pat_r, pat_g, pat_b;

    // Next-state for the active-pixel counter and bar position.
    always_comb begin
        pix_cnt_d = '0;
        bar_pos_d = '0;
        bar_idx_d = '0;
        if (color_en) begin
            pix_cnt_d = pix_cnt_q + 12'd1;
            if (pix_cnt_q != 12'hFFF) begin
                if (bar_pos_q == BarLast) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_pos_d = bar_pos_q + 12'd1;
                    bar_idx_d = bar_idx_q;
                end
            end
        end
    end

    // Pattern counter registers.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt_q <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black.
    assign pat_r = {8{~bar_idx_q[1]}};
    assign pat_g = {8{~bar_idx_q[2]}};
    assign pat_b = {8{~bar_idx_q[0]}};

    // ---------------------------------------------------------------------------------
    // Stage 1: source select and minimisation.
    logic [2:0][7:0] pix_d;
    logic [2:0][8:0] qm_d, qm_q;
    logic [2:0][3:0] n1_d, n1_q, n0_d, n0_q;
    logic            de_q, hs_q, vs_q;

    // Select pixel source and compute q_m with its ones/zeros counts.
    always_comb begin
        pix_d = pattern_en ? {pat_r, pat_g, pat_b} : {red_x, green_x, blue_x};
        qm_d  = '0;
        n1_d  = '0;
        n0_d  = '0;
        for (int c = 0; c < 3; c++) begin
            qm_d[c] = minimise(pix_d[c]);
            n1_d[c] = popcount8(qm_d[c][7:0]);
            n0_d[c] = 4'd8 - n1_d[c];
        end
    end

    // Stage 1 registers, with syncs and colour-enable delayed alongside the data.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            qm_q <= '0;
            n1_q <= '0;
            n0_q <= '0;
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            qm_q <= qm_d;
            n1_q <= n1_d;
            n0_q <= n0_d;
            de_q <= color_en;
            hs_q <= hsync ^ SYNC_INV;
            vs_q <= vsync ^ SYNC_INV;
        end
    end

    // ---------------------------------------------------------------------------------
    // Stage 2: DC balancing against the running disparity, or control symbols.
    logic [2:0][9:0] sym_d, sym_q;
    logic [2:0][4:0] cnt_d, cnt_q;

    // Symbol selection and disparity update per channel.
    always_comb begin
        logic [8:0]        qm;
        logic signed [4:0] n1s, n0s, cnt, delta;
        sym_d = '0;
        cnt_d = '0;
        qm    = '0;
        n1s   = '0;
        n0s   = '0;
        cnt   = '0;
        delta = '0;
        for (int c = 0; c < 3; c++) begin
            qm  = qm_q[c];
            n1s = {1'b0, n1_q[c]};
            n0s = {1'b0, n0_q[c]};
            cnt = $signed(cnt_q[c]);
            if (!de_q) begin
                sym_d[c] = (c == 0) ? ctrl_symbol({vs_q, hs_q}) : CtrlBlank;
                cnt_d[c] = '0;
            end else if (cnt == 5'sd0 || n1s == n0s) begin
                sym_d[c] = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                delta    = qm[8] ? (n1s - n0s) : (n0s - n1s);
                cnt_d[c] = cnt + delta;
            end else if ((cnt > 5'sd0 && n1s > n0s) || (cnt < 5'sd0 && n0s > n1s)) begin
                sym_d[c] = {1'b1, qm[8], ~qm[7:0]};
                delta    = $signed({3'b000, qm[8], 1'b0}) + n0s - n1s;
                cnt_d[c] = cnt + delta;
            end else begin
                sym_d[c] = {1'b0, qm[8], qm[7:0]};
                delta    = n1s - n0s - $signed({3'b000, ~qm[8], 1'b0});
                cnt_d[c] = cnt + delta;
            end
        end
    end

    // Output symbol and disparity registers; symbols clear to the blank control word.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            sym_q <= {CtrlBlank, CtrlBlank, CtrlBlank};
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign tmds_b = sym_q[0];
    assign tmds_g = sym_q[1];
    assign tmds_r = sym_q[2];

endmodule

// File: doc/dvi_tmds_encoder.md
# dvi_tmds_encoder

Parametrised three-channel DVI 1.0 TMDS encoder for the pixel-clock domain. Sits between the SoC VGA port (variable-depth RGB, sync and colour-enable) and the serialiser/ODDR stage. Adds bit-replicated colour expansion, configurable sync polarity, a built-in colour-bar test pattern and a fixed, matched pipeline latency.

## Interface

- RW, 5: red input width, 1..8.
- GW, 6: green input width, 1..8.
- BW, 5: blue input width, 1..8.
- SYNC_INV, 0: 1 inverts hsync/vsync before encoding.
- BAR_W, 80: colour-bar width in active pixels, 1..4095.

Ports:

- clk_pixel  in  1  pixel clock; the block's only clock.
- reset_n  in  1  asynchronous, active-low reset.
- red  in  RW  red component.
- green  in  GW  green component.
- blue  in  BW  blue component.
- color_en  in  1  active-video flag (1 = data period).
- hsync  in  1  horizontal sync.
- vsync  in  1  vertical sync.
- pattern_en  in  1  1 replaces the RGB inputs with colour bars.
- tmds_b  out  10  channel 0 symbol; carries the syncs.
- tmds_g  out  10  channel 1 symbol.
- tmds_r  out  10  channel 2 symbol.

## Operation

- **Colour expansion:** each component is widened to 8 bits by repeating the input MSB-first and keeping the top 8 bits.
  - 5-bit 0x1F -> 0xFF; 5-bit 0x10 -> 0x84.
  - 6-bit 0x20 -> 0x82.
  - Width 8 passes through unchanged.
- **Test pattern:**
  - An 12-bit active-pixel counter increments on each cycle with color_en=1.
  - It clears on the first cycle with color_en=0.
  - bar = (count / BAR_W) mod 8. Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black; each component is 0xFF or 0x00.
  - The counter runs whether or not pattern_en is set. pattern_en is sampled every cycle, with no line alignment.
- **Sync:** hsync/vsync are XORed with SYNC_INV.
- **Control period (color_en=0):**
  - Control bits: blue C0=hsync, C1=vsync; green and red C1C0=00.
  - Symbol for C1C0: 00 -> 0x354, 01 -> 0x0AB, 10 -> 0x154, 11 -> 0x2AB.
  - That channel's disparity counter is forced to 0.
- **Data period, per channel, DVI 1.0 algorithm:**
  - Minimisation: n1 = popcount(D). Use XNOR chaining when n1>4, or n1==4 and D[0]==0; otherwise XOR. q_m[8] = 1 for XOR, 0 for XNOR.
  - N1/N0 = ones/zeros in q_m[7:0]. cnt is a signed 5-bit counter.
  - Case cnt==0 or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? N1-N0 : N0-N1.
  - Case (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8] + N0-N1.
  - Otherwise: out = {0, q_m[8], q_m[7:0]}. cnt += N1-N0 - 2*(~q_m[8]).
  - cnt stays in -10..+10 and never saturates.

## Timing

- Two-stage pipeline; latency is 2 cycles from inputs to symbols.
  - Stage 1 registers the expanded/pattern data, q_m, N1/N0 and the delayed sync/color_en.
  - Stage 2 registers the output symbols and cnt.
- Sync and color_en travel in the same pipeline, so control/data alignment is exact.
- Reset (asynchronous assert, synchronous deassert by the upstream reset synchroniser):
  - All pipeline registers, cnt and the pattern counter go to 0.
  - All tmds_* outputs read 0x354 (blank, syncs low).
- Reset asserted mid-line: outputs become 0x354 immediately (combinationally via the registers' asynchronous clear). The first two cycles after release output 0x354 regardless of the inputs.
- color_en changing on consecutive cycles is legal.
  - A 1-cycle data period encodes with cnt starting at 0.
  - A 1-cycle blank emits exactly one control symbol and resets cnt.
- Parameter values outside their stated range are unsupported; elaboration fails via a generate-time check.

## Test plan

1. **Reset:** hold reset_n=0 with random inputs -> all outputs 0x354. Release -> 0x354 for 2 cycles, then the encoded inputs.
2. **Control symbols:** color_en=0, step {vsync,hsync} through 00,01,10,11 with SYNC_INV=0 -> tmds_b = 0x354, 0x0AB, 0x154, 0x2AB, 2 cycles later; tmds_g/tmds_r stay 0x354. Repeat with SYNC_INV=1 -> same sequence reversed.
3. **Disparity:** color_en=1, all components 0 for 6 cycles -> each channel emits 0x100, 0x3FF, 0x100, 0x3FF, 0x100, 0x3FF. cnt runs -8, 2, -6, 4, -4, 6.
4. **Expansion:** RW=5, red=0x10, one data cycle after a blank -> tmds_r equals the encoding of 0x84. GW=6, green=0x3F -> encoding of 0xFF.
5. **Pattern:** pattern_en=1, BAR_W=4, 32 active pixels -> the 8 bar colours for 4 pixels each, starting white. A 1-cycle color_en drop restarts at white.
6. **Reference model:** 10k random pixels with random blanking -> every symbol matches a reference DVI encoder model. Running disparity stays within ±10 and returns to 0 at each blank.
